alien_collision: RTL and testbench



---
 rtl/alien_collision_pkg.sv | 41 ++++
 rtl/alien_collision_if.sv | 36 +++
 rtl/alien_hit_decoder.sv | 47 ++++
 rtl/alien_collision.sv | 127 ++++++++++++
 tb/tb_alien_collision.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/alien_collision_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alien_collision_pkg
//  Description : Shared constants, FSM state type and scoring helper for the
//                alien collision stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package alien_collision_pkg;

  // Bullet rows at or above this value mean "no bullet in flight".
  localparam int c_BULLET_INACTIVE_Y = 13;

  localparam int c_SCREEN_W = 32;
  localparam int c_SCREEN_H = 16;

  // Points awarded per struck alien, by fleet row.
  localparam logic [7:0] c_POINTS_ROW0  = 8'd3;
  localparam logic [7:0] c_POINTS_ROW1  = 8'd2;
  localparam logic [7:0] c_POINTS_OTHER = 8'd1;

  // Collision FSM states.
  typedef enum logic [1:0] {
    ST_ARMED = 2'd0,
    ST_HIT   = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  // Points for a hit on the given fleet row.
  function automatic logic [7:0] row_points(input logic [1:0] row);
    logic [7:0] pts;
    pts = c_POINTS_OTHER;
    if (row == 2'd0) begin
      pts = c_POINTS_ROW0;
    end else if (row == 2'd1) begin
      pts = c_POINTS_ROW1;
    end
    return pts;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alien_collision_if.sv
`default_nettype none
// ============================================================================
//  Module      : alien_collision_if
//  Description : Bullet/fleet position inputs and fleet status outputs of the
//                alien collision stage.
//  Revision    : 1.0 - initial release
// ============================================================================
interface alien_collision_if #(
  parameter int ROWS = 4,
  parameter int COLS = 8
);

  logic [4:0]           i_bullet_x;
  logic [3:0]           i_bullet_y;
  logic [4:0]           i_fleet_x;
  logic [3:0]           i_fleet_y;
  logic                 i_new_wave;
  logic                 o_hit;
  logic [ROWS*COLS-1:0] o_alive;
  logic [7:0]           o_score;
  logic                 o_wave_clear;

  // Game side: drives positions and wave reload, observes results.
  modport master (
    output i_bullet_x, i_bullet_y, i_fleet_x, i_fleet_y, i_new_wave,
    input  o_hit, o_alive, o_score, o_wave_clear
  );

  // Collision stage side.
  modport slave (
    input  i_bullet_x, i_bullet_y, i_fleet_x, i_fleet_y, i_new_wave,
    output o_hit, o_alive, o_score, o_wave_clear
  );

endinterface
`default_nettype wire

// File: rtl/alien_hit_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : alien_hit_decoder
//  Description : Combinational mapping of a bullet position onto a fleet
//                slot. Aliens sit on even column offsets from the fleet
//                origin, one per row.
//  Revision    : 1.0 - initial release
// ============================================================================
module alien_hit_decoder
  import alien_collision_pkg::*;
#(
  parameter int ROWS = 4,
  parameter int COLS = 8
) (
  input  wire logic [4:0] bullet_x_i,
  input  wire logic [3:0] bullet_y_i,
  input  wire logic [4:0] fleet_x_i,
  input  wire logic [3:0] fleet_y_i,
  output logic            candidate_o,
  output logic [1:0]      row_o,
  output logic [3:0]      col_o,
  output logic [5:0]      index_o
);

  // Sign bit (bit 5) tells whether the bullet is left of / above the fleet.
  logic [5:0] dx_w;
  logic [5:0] dy_w;

  assign dx_w = {1'b0, bullet_x_i} - {1'b0, fleet_x_i};
  assign dy_w = {2'b00, bullet_y_i} - {2'b00, fleet_y_i};

  // Slot decode: non-negative even column offset inside the fleet width,
  // non-negative row offset inside the fleet height, and a live bullet.
  always_comb begin
    candidate_o = ~dx_w[5]
                & ~dx_w[0]
                & ({1'b0, dx_w[4:1]} < 5'(COLS))
                & ~dy_w[5]
                & (dy_w[4:0] < 5'(ROWS))
                & (bullet_y_i < 4'(c_BULLET_INACTIVE_Y));
    row_o   = dy_w[1:0];
    col_o   = dx_w[4:1];
    index_o = 6'(row_o) * 6'(COLS) + 6'(col_o);
  end

endmodule
`default_nettype wire

// File: rtl/alien_collision.sv
`default_nettype none
// ============================================================================
//  Module      : alien_collision
//  Description : Bullet-versus-fleet collision stage. Issues a one-cycle hit
//                pulse, clears the struck alien, accumulates a saturating
//                score and flags wave completion.
//  Revision    : 1.0 - initial release
// ============================================================================
module alien_collision
  import alien_collision_pkg::*;
#(
  parameter int ROWS = 4,
  parameter int COLS = 8
) (
  input  wire logic         i_clk_25MHz,
  input  wire logic         i_reset,
  alien_collision_if.slave  bus
);

  localparam int c_N = ROWS * COLS;

  state_t         state_q, state_d;
  logic           hit_q, hit_d;
  logic [c_N-1:0] alive_q, alive_d;
  logic [7:0]     score_q, score_d;
  logic           wave_clear_q, wave_clear_d;

  logic           cand_w;
  logic [1:0]     row_w;
  logic [3:0]     col_w;
  logic [5:0]     index_w;
  logic [c_N-1:0] mask_w;
  logic [c_N-1:0] alive_sel_w;
  logic           strike_w;
  logic [8:0]     score_sum_w;
  logic           bullet_idle_w;

  alien_hit_decoder #(
    .ROWS (ROWS),
    .COLS (COLS)
  ) u_decoder (
    .bullet_x_i  (bus.i_bullet_x),
    .bullet_y_i  (bus.i_bullet_y),
    .fleet_x_i   (bus.i_fleet_x),
    .fleet_y_i   (bus.i_fleet_y),
    .candidate_o (cand_w),
    .row_o       (row_w),
    .col_o       (col_w),
    .index_o     (index_w)
  );

  // One-hot clear mask for the decoded slot.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      assign mask_w[r*COLS+c] = (row_w == 2'(r)) && (col_w == 4'(c));
    end
  end

  assign alive_sel_w   = alive_q >> index_w;
  assign strike_w      = cand_w & alive_sel_w[0];
  assign score_sum_w   = {1'b0, score_q} + {1'b0, row_points(row_w)};
  assign bullet_idle_w = (bus.i_bullet_y >= 4'(c_BULLET_INACTIVE_Y));

  // State, bitmap, score and wave flag registers.
  always_ff @(posedge i_clk_25MHz or posedge i_reset) begin
    if (i_reset) begin
      state_q      <= ST_ARMED;
      hit_q        <= 1'b0;
      alive_q      <= '1;
      score_q      <= 8'd0;
      wave_clear_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      hit_q        <= hit_d;
      alive_q      <= alive_d;
      score_q      <= score_d;
      wave_clear_q <= wave_clear_d;
    end
  end

  // Next-state logic; a wave reload overrides any strike in the same cycle.
  always_comb begin
    state_d = state_q;
    hit_d   = 1'b0;
    alive_d = alive_q;
    score_d = score_q;

    case (state_q)
      ST_ARMED: begin
        if (strike_w) begin
          state_d = ST_HIT;
          hit_d   = 1'b1;
          alive_d = alive_q & ~mask_w;
          score_d = score_sum_w[8] ? 8'hFF : score_sum_w[7:0];
        end
      end
      ST_HIT: begin
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (bullet_idle_w) begin
          state_d = ST_ARMED;
        end
      end
      default: begin
        state_d = ST_ARMED;
      end
    endcase

    if (bus.i_new_wave) begin
      state_d = ST_ARMED;
      hit_d   = 1'b0;
      alive_d = '1;
      score_d = score_q;
    end

    // Flag follows the bitmap one cycle late; a reload drops it at once.
    wave_clear_d = bus.i_new_wave ? 1'b0 : (alive_q == '0);
  end

  assign bus.o_hit        = hit_q;
  assign bus.o_alive      = alive_q;
  assign bus.o_score      = score_q;
  assign bus.o_wave_clear = wave_clear_q;

endmodule
`default_nettype wire

// File: tb/tb_alien_collision.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alien_collision
//  Description : Self-checking bench for alien_collision against a slot-level
//                game model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alien_collision;

  localparam int ROWS = 4;
  localparam int COLS = 8;

  logic clk = 1'b0;
  logic rst;

  always #20 clk = ~clk;

  alien_collision_if #(.ROWS(ROWS), .COLS(COLS)) u_bus ();

  alien_collision #(.ROWS(ROWS), .COLS(COLS)) dut (
    .i_clk_25MHz (clk),
    .i_reset     (rst),
    .bus         (u_bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Game model: which aliens live, score, and bullet-lock behaviour.
  bit m_alive [ROWS][COLS];
  int m_score;
  bit m_hit;
  bit m_locked;
  bit m_wclear;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] model_alive_vec();
    logic [63:0] v;
    v = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        v[r*COLS+c] = m_alive[r][c];
    return v;
  endfunction

  function automatic int alive_count();
    int n;
    n = 0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        n += int'(m_alive[r][c]);
    return n;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        m_alive[r][c] = 1'b1;
    m_score  = 0;
    m_hit    = 1'b0;
    m_locked = 1'b0;
    m_wclear = 1'b0;
  endtask

  // Advance the model by one clock using the inputs presented at that edge.
  task automatic model_edge();
    int bx, by, fx, fy, pts;
    bit nw, was_empty, struck;
    bx = int'(u_bus.i_bullet_x);
    by = int'(u_bus.i_bullet_y);
    fx = int'(u_bus.i_fleet_x);
    fy = int'(u_bus.i_fleet_y);
    nw = u_bus.i_new_wave;
    was_empty = (alive_count() == 0);
    struck = 1'b0;
    if (nw) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          m_alive[r][c] = 1'b1;
      m_hit    = 1'b0;
      m_locked = 1'b0;
    end else if (m_hit) begin
      m_hit    = 1'b0;
      m_locked = 1'b1;
    end else if (m_locked) begin
      if (by >= 13) m_locked = 1'b0;
    end else if (by < 13) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          if (!struck && bx == fx + 2*c && by == fy + r && m_alive[r][c]) begin
            struck = 1'b1;
            m_alive[r][c] = 1'b0;
            pts = (r == 0) ? 3 : (r == 1) ? 2 : 1;
            m_score = (m_score + pts > 255) ? 255 : m_score + pts;
          end
      m_hit = struck;
    end
    m_wclear = nw ? 1'b0 : was_empty;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".hit"},   64'(u_bus.o_hit),        64'(m_hit));
    check({tag, ".alive"}, 64'(u_bus.o_alive),      model_alive_vec());
    check({tag, ".score"}, 64'(u_bus.o_score),      64'(m_score));
    check({tag, ".wclr"},  64'(u_bus.o_wave_clear), 64'(m_wclear));
  endtask

  task automatic drive(input int bx, input int by, input int fx, input int fy, input bit nw);
    u_bus.i_bullet_x = 5'(bx);
    u_bus.i_bullet_y = 4'(by);
    u_bus.i_fleet_x  = 5'(fx);
    u_bus.i_fleet_y  = 4'(fy);
    u_bus.i_new_wave = nw;
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  // Strike alien (r,c) of a fleet at (4,2), then retire the bullet.
  task automatic hit_alien(input int r, input int c);
    if (!m_alive[r][c]) begin
      drive(0, 15, 4, 2, 1'b1);
      step("reload");
    end
    drive(4 + 2*c, 2 + r, 4, 2, 1'b0);
    step("strike");
    drive(0, 15, 4, 2, 1'b0);
    step("retire");
    step("rearm");
  endtask

  int hits;

  initial begin
    rst = 1'b1;
    drive(0, 15, 4, 2, 1'b0);
    model_reset();
    #5;
    check_all("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Basic strike on row 1, column 2.
    drive(8, 3, 4, 2, 1'b0);
    step("hit10");
    check("hit10.pulse", 64'(u_bus.o_hit), 64'd1);
    check("hit10.score", 64'(u_bus.o_score), 64'd2);
    step("hit10.hold");
    drive(0, 15, 4, 2, 1'b0);
    step("hit10.idle");

    // Odd column offset, then a dead alien.
    drive(9, 3, 4, 2, 1'b0);
    step("odd");
    step("odd2");
    drive(8, 3, 4, 2, 1'b0);
    step("dead");
    step("dead2");

    // Bullet parked on an alien: only one hit.
    drive(4, 2, 4, 2, 1'b0);
    hits = 0;
    for (int i = 0; i < 10; i++) begin
      step("park");
      hits += int'(u_bus.o_hit);
    end
    check("park.single", 64'(hits), 64'd1);
    drive(0, 15, 4, 2, 1'b0);
    step("park.idle");
    drive(6, 2, 4, 2, 1'b0);
    step("second");
    check("second.score", 64'(u_bus.o_score), 64'd8);
    drive(0, 15, 4, 2, 1'b0);
    step("second.idle");
    step("second.idle2");

    // Reload coinciding with a live strike.
    drive(10, 2, 4, 2, 1'b1);
    step("nw_strike");
    check("nw_strike.hit", 64'(u_bus.o_hit), 64'd0);
    check("nw_strike.alive", 64'(u_bus.o_alive), 64'hFFFF_FFFF);
    drive(0, 15, 4, 2, 1'b0);
    step("nw.idle");

    // Clear the whole fleet.
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        hit_alien(r, c);
    check("clear.flag", 64'(u_bus.o_wave_clear), 64'd1);
    drive(0, 15, 4, 2, 1'b1);
    step("clear.reload");
    check("clear.drop", 64'(u_bus.o_wave_clear), 64'd0);
    drive(0, 15, 4, 2, 1'b0);
    step("clear.after");

    // Drive the score up to 254, then saturate.
    while (254 - m_score >= 3) begin
      int c;
      c = 0;
      while (c < COLS && !m_alive[0][c]) c++;
      hit_alien(0, (c < COLS) ? c : 0);
    end
    if (254 - m_score == 2) hit_alien(1, 0);
    else if (254 - m_score == 1) hit_alien(2, 0);
    check("sat.254", 64'(u_bus.o_score), 64'd254);
    drive(0, 15, 4, 2, 1'b1);
    step("sat.reload");
    hit_alien(0, 3);
    check("sat.255", 64'(u_bus.o_score), 64'd255);
    hit_alien(0, 4);
    check("sat.hold", 64'(u_bus.o_score), 64'd255);

    // Asynchronous reset while the hit pulse is high.
    drive(4 + 2*5, 2, 4, 2, 1'b0);
    step("rst_hit");
    check("rst_hit.pre", 64'(u_bus.o_hit), 64'd1);
    #5;
    rst = 1'b1;
    #1;
    model_reset();
    check_all("rst_hit.async");
    check("rst_hit.score", 64'(u_bus.o_score), 64'd0);
    @(negedge clk);
    drive(0, 15, 4, 2, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Randomised play.
    for (int i = 0; i < 1500; i++) begin
      int fx, fy, bx, by;
      fx = int'($urandom_range(0, 31));
      fy = int'($urandom_range(0, 12));
      bx = (fx + int'($urandom_range(0, 2*COLS))) & 31;
      if ($urandom_range(0, 99) < 85) by = (fy + int'($urandom_range(0, ROWS))) & 15;
      else by = int'($urandom_range(13, 15));
      drive(bx, by, fx, fy, ($urandom_range(0, 99) < 3));
      step("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
